// File: rtl/pe_weight_wrt_arbiter.sv
// pe_weight_wrt_arbiter: shares the weight write port between the memory loader and the PE core.
// Memory has priority; colliding core writes are queued in order, and a burst limiter forces FIFO progress.
module pe_weight_wrt_arbiter #(
    parameter int weightAddrLen = 5,
    parameter int dataLen       = 16,
    parameter int logFifoDepth  = 2,
    parameter int maxMemBurst   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_wrt_valid,
    output logic                     mem_wrt_ready,
    input  logic [weightAddrLen-1:0] mem_wrt_addr,
    input  logic [dataLen-1:0]       mem_wrt_data,
    input  logic                     core_wrt_valid,
    input  logic [weightAddrLen-1:0] core_wrt_addr,
    input  logic [dataLen-1:0]       core_wrt_data,
    output logic                     core_wrt_stall,
    output logic                     weight_wrt,
    output logic [weightAddrLen-1:0] weight_wrt_addr,
    output logic [dataLen-1:0]       weight_wrt_data,
    output logic                     fifo_empty,
    output logic                     overflow_err
);
    localparam int DEPTH = 2 ** logFifoDepth;
    localparam int BW    = $clog2(maxMemBurst + 1);
    localparam int EW    = weightAddrLen + dataLen;

    typedef enum logic {MEM_PRI, CORE_TURN} state_t;

    state_t                state, state_nxt;
    logic [logFifoDepth:0] count;
    logic [logFifoDepth-1:0] rd_ptr, wr_ptr;
    logic [BW-1:0]         burst_cnt, burst_nxt;
    logic [EW-1:0]         fifo [DEPTH];
    logic [EW-1:0]         wr_sel;
    logic                  core_ok, g_mem, g_fifo, g_byp, push, pop;

    assign mem_wrt_ready  = state == MEM_PRI;
    assign core_wrt_stall = count == (logFifoDepth+1)'(DEPTH);
    assign fifo_empty     = count == '0;

    always_comb begin
        core_ok   = core_wrt_valid && !core_wrt_stall;
        g_mem     = mem_wrt_valid && mem_wrt_ready;
        g_fifo    = !g_mem && !fifo_empty;
        g_byp     = !g_mem && !g_fifo && core_ok;
        push      = core_ok && (g_mem || g_fifo);
        pop       = g_fifo;
        wr_sel    = g_mem ? {mem_wrt_addr, mem_wrt_data} : g_fifo ? fifo[rd_ptr] : {core_wrt_addr, core_wrt_data};
        burst_nxt = '0;
        state_nxt = MEM_PRI;
        // CORE_TURN is only entered with a non-empty FIFO, so it always pops the head
        if (g_mem && !fifo_empty) begin
            if (burst_cnt == BW'(maxMemBurst - 1)) state_nxt = CORE_TURN;
            else burst_nxt = burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= MEM_PRI;
            burst_cnt       <= '0;
            count           <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            weight_wrt      <= 1'b0;
            weight_wrt_addr <= '0;
            weight_wrt_data <= '0;
            overflow_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_nxt;
            rd_ptr     <= rd_ptr + logFifoDepth'(pop);
            wr_ptr     <= wr_ptr + logFifoDepth'(push);
            count      <= count + (logFifoDepth+1)'(push) - (logFifoDepth+1)'(pop);
            weight_wrt <= g_mem || g_fifo || g_byp;
            if (g_mem || g_fifo || g_byp) {weight_wrt_addr, weight_wrt_data} <= wr_sel;
            if (core_wrt_valid && core_wrt_stall) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {core_wrt_addr, core_wrt_data};
    end
endmodule

// File: tb/tb_pe_weight_wrt_arbiter.sv
// tb_pe_weight_wrt_arbiter: randomized and directed stimulus checked against a queue-based
// reference model of the arbitration rules.
module tb_pe_weight_wrt_arbiter;
    localparam int MB = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_wrt_valid, core_wrt_valid;
    logic [4:0]  mem_wrt_addr, core_wrt_addr;
    logic [15:0] mem_wrt_data, core_wrt_data;
    logic        mem_wrt_ready, core_wrt_stall, weight_wrt, fifo_empty, overflow_err;
    logic [4:0]  weight_wrt_addr;
    logic [15:0] weight_wrt_data;

    pe_weight_wrt_arbiter #(.weightAddrLen(5), .dataLen(16), .logFifoDepth(2), .maxMemBurst(MB)) dut (
        .clk(clk), .reset(reset),
        .mem_wrt_valid(mem_wrt_valid), .mem_wrt_ready(mem_wrt_ready),
        .mem_wrt_addr(mem_wrt_addr), .mem_wrt_data(mem_wrt_data),
        .core_wrt_valid(core_wrt_valid), .core_wrt_addr(core_wrt_addr),
        .core_wrt_data(core_wrt_data), .core_wrt_stall(core_wrt_stall),
        .weight_wrt(weight_wrt), .weight_wrt_addr(weight_wrt_addr),
        .weight_wrt_data(weight_wrt_data), .fifo_empty(fifo_empty),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [20:0] m_q[$];
    int          m_burst;
    bit          m_turn, m_ovf, e_wrt;
    logic [4:0]  e_addr;
    logic [15:0] e_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_burst = 0;
        m_turn  = 0;
        m_ovf   = 0;
        e_wrt   = 0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    // One clock of the arbitration rules applied to the current inputs
    task automatic model_step(input logic v_m, input logic [4:0] a_m, input logic [15:0] d_m,
                              input logic v_c, input logic [4:0] a_c, input logic [15:0] d_c);
        bit full, core_ok, nonempty, next_turn;
        full      = m_q.size() == DEPTH;
        nonempty  = m_q.size() != 0;
        core_ok   = v_c && !full;
        next_turn = 0;
        if (v_c && full) m_ovf = 1;
        if (v_m && !m_turn) begin
            e_wrt = 1; e_addr = a_m; e_data = d_m;
            if (nonempty) begin
                m_burst++;
                if (m_burst == MB) begin next_turn = 1; m_burst = 0; end
            end else m_burst = 0;
            if (core_ok) m_q.push_back({a_c, d_c});
        end else begin
            m_burst = 0;
            if (nonempty) begin
                e_wrt = 1; {e_addr, e_data} = m_q.pop_front();
                if (core_ok) m_q.push_back({a_c, d_c});
            end else if (core_ok) begin
                e_wrt = 1; e_addr = a_c; e_data = d_c;
            end else e_wrt = 0;
        end
        m_turn = next_turn;
    endtask

    task automatic check_all();
        chk("weight_wrt", 32'(weight_wrt), 32'(e_wrt));
        chk("weight_wrt_addr", 32'(weight_wrt_addr), 32'(e_addr));
        chk("weight_wrt_data", 32'(weight_wrt_data), 32'(e_data));
        chk("mem_wrt_ready", 32'(mem_wrt_ready), 32'(!m_turn));
        chk("core_wrt_stall", 32'(core_wrt_stall), 32'(m_q.size() == DEPTH));
        chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    endtask

    task automatic cycle(input logic v_m, input logic [4:0] a_m, input logic [15:0] d_m,
                         input logic v_c, input logic [4:0] a_c, input logic [15:0] d_c);
        mem_wrt_valid = v_m; mem_wrt_addr = a_m; mem_wrt_data = d_m;
        core_wrt_valid = v_c; core_wrt_addr = a_c; core_wrt_data = d_c;
        model_step(v_m, a_m, d_m, v_c, a_c, d_c);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 16'd0, 0, 5'd0, 16'd0);
    endtask

    task automatic rand_cycles(input int n, input int pm, input int pc);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(99) < pm, 5'($urandom), 16'($urandom),
                  $urandom_range(99) < pc, 5'($urandom), 16'($urandom));
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_wrt", 32'(weight_wrt), 32'd0);
        chk("rst_async_addr", 32'(weight_wrt_addr), 32'd0);
        chk("rst_async_data", 32'(weight_wrt_data), 32'd0);
        chk("rst_async_empty", 32'(fifo_empty), 32'd1);
        model_reset();
        mem_wrt_valid = 0; core_wrt_valid = 0;
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mem_wrt_valid = 0; mem_wrt_addr = '0; mem_wrt_data = '0;
        core_wrt_valid = 0; core_wrt_addr = '0; core_wrt_data = '0;
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // core write alone
        cycle(0, 5'd0, 16'd0, 1, 5'd3, 16'h1234);
        chk("core_alone_addr", 32'(weight_wrt_addr), 32'd3);
        chk("core_alone_data", 32'(weight_wrt_data), 32'h1234);
        idle(1);

        // mem and core collide, core retires next
        cycle(1, 5'h5, 16'hAAAA, 1, 5'h7, 16'hBBBB);
        chk("collide_mem_addr", 32'(weight_wrt_addr), 32'h5);
        chk("collide_queued", 32'(fifo_empty), 32'd0);
        cycle(0, 5'd0, 16'd0, 0, 5'd0, 16'd0);
        chk("collide_core_data", 32'(weight_wrt_data), 32'hBBBB);
        idle(2);

        // long memory load with 5 core writes: stall, overflow, CORE_TURN
        for (int i = 0; i < 20; i++)
            cycle(1, 5'(i), 16'(16'h1000 + i), i < 5, 5'(16 + i), 16'(16'hC000 + i));
        idle(6);
        chk("overflow_sticky", 32'(overflow_err), 32'd1);

        // reset with 3 entries queued
        for (int i = 0; i < 3; i++) cycle(1, 5'(i), 16'(i), 1, 5'(8 + i), 16'(16'hD000 + i));
        mid_reset();
        idle(4);

        // pop+push with 3 queued and mem idle
        for (int i = 0; i < 3; i++) cycle(1, 5'(i), 16'(i), 1, 5'(20 + i), 16'(16'hE000 + i));
        for (int i = 0; i < 4; i++) cycle(0, 5'd0, 16'd0, 1, 5'(24 + i), 16'(16'hF000 + i));
        idle(6);

        mid_reset();
        rand_cycles(300, 90, 40);
        mid_reset();
        rand_cycles(300, 50, 50);
        mid_reset();
        rand_cycles(300, 95, 20);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
